// File: rtl/run_monitor.sv
// Run monitor: tracks one program run from start to halt, error or timeout.
// Counts run cycles and retired instructions and reports the terminating source.
module run_monitor #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 10000,
  parameter int N_SRC      = 1,
  localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             retire,
  input  logic [N_SRC-1:0] halt_in,
  input  logic [N_SRC-1:0] err_in,
  output logic [2:0]       state,
  output logic             done,
  output logic [SRC_W-1:0] src_id,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count
);

  if (MAX_CYCLES < 1 || MAX_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_max
    $error("run_monitor: MAX_CYCLES out of range for CNT_W");
  end

  if (N_SRC < 1) begin : g_bad_src
    $error("run_monitor: N_SRC must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_HALTED  = 3'd2,
    S_TIMEOUT = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Scan high to low so the last hit is the lowest set index.
  function automatic logic [SRC_W-1:0] lowest(
    input logic [N_SRC-1:0] v
  );
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = SRC_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    src_d   = src_q;
    inst_d  = inst_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          src_d   = '0;
          inst_d  = '0;
          cyc_d   = '0;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
        end else begin
          cyc_d = sat_inc(cyc_q);
          if (retire) inst_d = sat_inc(inst_q);
          if (|err_in) begin
            state_d = S_ERROR;
            src_d   = lowest(err_in);
            done_d  = 1'b1;
          end else if (|halt_in) begin
            state_d = S_HALTED;
            src_d   = lowest(halt_in);
            done_d  = 1'b1;
          end else if (cyc_q == LAST_CYC) begin
            state_d = S_TIMEOUT;
            done_d  = 1'b1;
          end
        end
      end
      S_HALTED, S_TIMEOUT, S_ERROR: begin
        if (clear) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      src_q   <= '0;
      inst_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      src_q   <= src_d;
      inst_q  <= inst_d;
      cyc_q   <= cyc_d;
    end
  end

  assign state       = state_q;
  assign done        = done_q;
  assign src_id      = src_q;
  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;

endmodule
